// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the 5-stage core: hazard FSM states, watchdog limits,
// flush NOP encoding and a saturating-increment helper.
package riscv_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StError   = 2'd2
  } hz_state_e;

  localparam int unsigned MemTimeoutMin = 2;
  localparam int unsigned MemTimeoutMax = 255;

  // addi x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_wait_watchdog.sv
// Counts frozen cycles of a data-memory wait and pulses expire on the cycle that would be
// the MEM_TIMEOUT-th consecutive freeze.
module mem_wait_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic expire
);

  localparam logic [7:0] Limit = 8'(MEM_TIMEOUT - 1);

  logic [7:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (clr) begin
      wait_cnt <= '0;
    end else if (inc) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign expire = inc && (wait_cnt == Limit);

endmodule

// File: rtl/hazard_controller.sv
// Load-use / branch-flush / memory-freeze sequencer with a memory-wait watchdog.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IF_ID_Rs1,
  input  logic [4:0]  IF_ID_Rs2,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rd,
  input  logic        EX_BranchTaken,
  input  logic        EX_MEM_MemReq,
  input  logic        dmem_ready,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        pipe_freeze,
`ifdef HAZARD_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_freeze_cnt,
`endif
  output logic        mem_timeout_err
);

  if (MEM_TIMEOUT < MemTimeoutMin || MEM_TIMEOUT > MemTimeoutMax) begin : g_bad_timeout
    $error("hazard_controller: MEM_TIMEOUT outside 2..255");
  end

  hz_state_e state_q, state_d;
  logic mem_stall, load_use, expire, wd_inc, wd_clr;

  assign mem_stall = EX_MEM_MemReq && !dmem_ready;
  assign load_use  = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                     ((ID_EX_Rd == IF_ID_Rs1) || (ID_EX_Rd == IF_ID_Rs2));

  // ERROR ignores inputs, so the counter is frozen there too.
  assign wd_inc = mem_stall && (state_q != StError);
  assign wd_clr = (state_d == StRun);

  mem_wait_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .inc   (wd_inc),
    .clr   (wd_clr),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:     if (mem_stall) state_d = StMemWait;
      StMemWait: begin
        if (expire) begin
          state_d = StError;
        end else if (dmem_ready) begin
          state_d = StRun;
        end
      end
      StError:   state_d = StError;
      default:   state_d = StRun;
    endcase
  end

  always_comb begin
    PCWrite         = 1'b0;
    IF_ID_Write     = 1'b0;
    IF_ID_Flush     = 1'b0;
    ID_EX_Flush     = 1'b0;
    pipe_freeze     = 1'b0;
    mem_timeout_err = 1'b0;
    if (reset) begin
      // all outputs held low while in reset
    end else if (state_q == StError) begin
      pipe_freeze     = 1'b1;
      mem_timeout_err = 1'b1;
    end else if (mem_stall) begin
      pipe_freeze = 1'b1;
    end else if (EX_BranchTaken) begin
      // A coincident load-use belongs to the wrong path and is dropped.
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      PCWrite     = 1'b1;
      IF_ID_Write = 1'b1;
    end else if (load_use) begin
      ID_EX_Flush = 1'b1;
    end else begin
      PCWrite     = 1'b1;
      IF_ID_Write = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q, perf_freeze_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_q  <= '0;
      perf_flush_q  <= '0;
      perf_freeze_q <= '0;
    end else begin
      if (ID_EX_Flush && !IF_ID_Flush) perf_stall_q <= sat_inc(perf_stall_q);
      if (IF_ID_Flush) perf_flush_q <= sat_inc(perf_flush_q);
      if (pipe_freeze) perf_freeze_q <= sat_inc(perf_freeze_q);
    end
  end

  assign perf_stall_cnt  = perf_stall_q;
  assign perf_flush_cnt  = perf_flush_q;
  assign perf_freeze_cnt = perf_freeze_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios followed by randomized
// traffic, compared against a rule-level reference model.
module tb_hazard_controller;

  localparam int unsigned Timeout = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] IF_ID_Rs1 = '0, IF_ID_Rs2 = '0, ID_EX_Rd = '0;
  logic       ID_EX_MemRead = 1'b0, EX_BranchTaken = 1'b0, EX_MEM_MemReq = 1'b0;
  logic       dmem_ready = 1'b1;
  logic       PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, pipe_freeze, mem_timeout_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt;
`endif

  hazard_controller #(
    .MEM_TIMEOUT(Timeout)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .IF_ID_Rs1      (IF_ID_Rs1),
    .IF_ID_Rs2      (IF_ID_Rs2),
    .ID_EX_MemRead  (ID_EX_MemRead),
    .ID_EX_Rd       (ID_EX_Rd),
    .EX_BranchTaken (EX_BranchTaken),
    .EX_MEM_MemReq  (EX_MEM_MemReq),
    .dmem_ready     (dmem_ready),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .IF_ID_Flush    (IF_ID_Flush),
    .ID_EX_Flush    (ID_EX_Flush),
    .pipe_freeze    (pipe_freeze),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_freeze_cnt(perf_freeze_cnt),
`endif
    .mem_timeout_err(mem_timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: consecutive frozen-cycle count and sticky error flag.
  int          m_frozen = 0;
  bit          m_err    = 1'b0;
  logic [31:0] m_stall = '0, m_flush = '0, m_freeze = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, pipe_freeze, mem_timeout_err}
  function automatic logic [5:0] model_out();
    bit ms, lu;
    if (reset) return 6'b000000;
    if (m_err) return 6'b000011;
    ms = EX_MEM_MemReq && !dmem_ready;
    lu = ID_EX_MemRead && ID_EX_Rd != 0 && (ID_EX_Rd == IF_ID_Rs1 || ID_EX_Rd == IF_ID_Rs2);
    if (ms) return 6'b000010;
    if (EX_BranchTaken) return 6'b111100;
    if (lu) return 6'b000100;
    return 6'b110000;
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  function automatic logic [31:0] dut_out();
    return {26'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, pipe_freeze,
            mem_timeout_err};
  endfunction

  task automatic model_reset();
    m_frozen = 0;
    m_err    = 1'b0;
    m_stall  = '0;
    m_flush  = '0;
    m_freeze = '0;
  endtask

  task automatic step(input string tag, input bit ld, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input bit br,
                      input bit req, input bit rdy);
    logic [5:0] exp;
    @(negedge clk);
    ID_EX_MemRead  = ld;
    ID_EX_Rd       = rd;
    IF_ID_Rs1      = rs1;
    IF_ID_Rs2      = rs2;
    EX_BranchTaken = br;
    EX_MEM_MemReq  = req;
    dmem_ready     = rdy;
    #1;
    exp = model_out();
    check(tag, dut_out(), {26'd0, exp});
    @(posedge clk);
    if (exp[3] && !exp[2]) m_stall = sat(m_stall);
    if (exp[2]) m_flush = sat(m_flush);
    if (exp[1]) m_freeze = sat(m_freeze);
    if (!m_err) begin
      if (req && !rdy) begin
        m_frozen++;
        if (m_frozen == Timeout) m_err = 1'b1;
      end else if (rdy) begin
        m_frozen = 0;
      end
    end
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check(tag, dut_out(), 32'd0);
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #1;
    check("reset_outputs", dut_out(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    step("idle", 0, 0, 0, 0, 0, 0, 1);
    step("load_use", 1, 5, 1, 5, 0, 0, 1);
    step("after_load_use", 0, 5, 1, 5, 0, 0, 1);
    step("load_x0", 1, 0, 0, 3, 0, 0, 1);
    step("branch_over_load_use", 1, 7, 7, 2, 1, 0, 1);
    step("memreq_ready", 1, 7, 7, 2, 0, 1, 1);
    for (int i = 0; i < 3; i++) step("wait3_freeze", 0, 0, 0, 0, 1, 1, 0);
    step("wait3_release_branch", 0, 0, 0, 0, 1, 1, 1);
    // A second 3-cycle wait must not trip the timeout if the count was cleared.
    for (int i = 0; i < 3; i++) step("wait_again", 0, 0, 0, 0, 0, 1, 0);
    step("wait_again_release", 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step("timeout_freeze", 0, 0, 0, 0, 0, 1, 0);
    step("timeout_error", 0, 0, 0, 0, 0, 1, 0);
    step("error_sticky_ready", 1, 3, 3, 0, 1, 1, 1);
    step("error_sticky_idle", 0, 0, 0, 0, 0, 0, 1);
    pulse_reset("reset_in_error");
    step("after_reset", 0, 0, 0, 0, 0, 0, 1);

`ifdef HAZARD_PERF_EN
    pulse_reset("perf_reset");
    step("perf_bubble1", 1, 4, 4, 0, 0, 0, 1);
    step("perf_bubble2", 1, 6, 0, 6, 0, 0, 1);
    step("perf_branch", 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step("perf_freeze", 0, 0, 0, 0, 0, 1, 0);
    step("perf_release", 0, 0, 0, 0, 0, 1, 1);
    #1;
    check("perf_stall_2", perf_stall_cnt, 32'd2);
    check("perf_flush_1", perf_flush_cnt, 32'd1);
    check("perf_freeze_3", perf_freeze_cnt, 32'd3);
    @(negedge clk);
    force dut.perf_stall_q  = 32'hFFFF_FFFF;
    force dut.perf_flush_q  = 32'hFFFF_FFFF;
    force dut.perf_freeze_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_stall_q;
    release dut.perf_flush_q;
    release dut.perf_freeze_q;
    m_stall  = 32'hFFFF_FFFF;
    m_flush  = 32'hFFFF_FFFF;
    m_freeze = 32'hFFFF_FFFF;
    step("sat_bubble", 1, 4, 4, 0, 0, 0, 1);
    step("sat_branch", 0, 0, 0, 0, 1, 0, 1);
    step("sat_freeze", 0, 0, 0, 0, 0, 1, 0);
    step("sat_release", 0, 0, 0, 0, 0, 1, 1);
    #1;
    check("perf_stall_sat", perf_stall_cnt, 32'hFFFF_FFFF);
    check("perf_flush_sat", perf_flush_cnt, 32'hFFFF_FFFF);
    check("perf_freeze_sat", perf_freeze_cnt, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        pulse_reset("rand_reset");
      end else begin
        step("rand",
             1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) < 6));
      end
`ifdef HAZARD_PERF_EN
      #1;
      check("rand_perf_stall", perf_stall_cnt, m_stall);
      check("rand_perf_flush", perf_flush_cnt, m_flush);
      check("rand_perf_freeze", perf_freeze_cnt, m_freeze);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
